vecmac_lane_feeder: RTL and testbench
=====================================

// Module: vecmac_lane_feeder
// PURPOSE
//  Producer side of the partial-sum interface consumed by accumulator_var.
//  Accepts up to 16 unsigned int8 operand pairs per beat and multiplies each pair.
//  Reduces the active lanes to one unsigned partial_sum and drives ps_valid/partial_sum.
//  Emits ceil(ELEMS/lanes) beats per vector, masking unused lanes on the final beat.
// PARAMETERS
//  ELEMS   1000  elements per vector
//  MAXL    16    physical lanes (fixed; lanes_i range 1..16)
//  W_OUT   20    partial_sum width (16*255*255 = 1040400 < 2^20)
// PORTS
//  clk         in   1        clock, all logic on rising edge
//  rst         in   1        synchronous, active-high reset
//  start       in   1        pulse: latch lanes_i, begin a vector (ignored unless IDLE)
//  lanes_i     in   5        active lanes: 1/2/4/8/16
//  in_valid    in   1        operand beat valid
//  in_ready    out  1        feeder accepts beat (high only in RUN)
//  a_i         in   MAXL*8   operand A, lane k = a_i[8k+7:8k], unsigned
//  b_i         in   MAXL*8   operand B, same packing
//  ps_valid    out  1        partial_sum valid (drives accumulator in_valid)
//  partial_sum out  W_OUT    reduced sum of active-lane products
//  ps_last     out  1        marks final beat of vector (with ps_valid)
//  done        out  1        one-cycle pulse after last beat leaves pipeline
//  cfg_err     out  1        one-cycle pulse: illegal lanes_i at start
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0; pipeline valids cleared.
//  FSM: IDLE -start-> RUN -last beat accepted-> DRAIN -pipe empty-> IDLE (done=1 on exit).
//  Config: lanes_i latched on start; illegal value (0, 3, 5-7, 9-15, >16) -> lanes=1, cfg_err=1.
//  Handshake: beat accepted when in_valid && in_ready; no downstream backpressure.
//  No combinational path in_valid -> in_ready.
//  Beat count: beats = ceil(ELEMS/lanes). elem_cnt advances by lanes per accepted beat.
//  Lane mask: lane k active iff k < lanes && elem_cnt+k < ELEMS; inactive lane product forced 0.
//  Example: ELEMS=1000, lanes=16 -> 63 beats; last beat uses lanes 0..7 only.
//  Pipeline: S1 registers masked 16-bit products; S2 registers W_OUT-bit adder-tree sum.
//  Latency: accepted beat -> ps_valid exactly 2 cycles later. Gaps in in_valid reproduce as ps_valid gaps.
//  ps_last accompanies the beat with the final element.
//  done asserts the cycle after the ps_last beat is presented.
//  in_ready drops the cycle after the last beat is accepted; low in DRAIN and IDLE.
//  start while RUN/DRAIN: ignored; no cfg_err.
//  start and in_valid in same cycle from IDLE: that beat is not accepted (in_ready=0).
//  Reset mid-vector: next cycle ps_valid=0, ps_last=0, done=0, state IDLE; partial vector discarded.
//  Arithmetic: all unsigned, no saturation needed; the sum cannot overflow W_OUT.
// TESTING
//  lanes=16, all a=b=255, in_valid steady -> 63 beats.
//    Beats 0-61: partial_sum=1040400; beat 62: 520200 with ps_last.
//    done 1 cycle after ps_last; accumulator total = 65025000.
//  lanes=1, a0=3, b0=5, other lanes 0xFF -> 1000 beats each 15.
//    Upper lanes ignored; total 15000; first ps_valid 2 cycles after first accept.
//  lanes=4, in_valid toggled 1/0 -> 250 ps_valid pulses, spaced like the input gaps.
//    Per-beat sum correct for random operands vs. golden model.
//  lanes=3 at start -> cfg_err pulse; runs as lanes=1 (1000 beats).
//    Second start mid-RUN is ignored.
//  rst asserted at accepted beat 10 of a lanes=8 vector -> ps_valid low next cycle, no done.
//    A new start afterwards runs a clean 125-beat vector.
//  All operands 0 with lanes=2 -> 500 beats of partial_sum=0; ps_last on beat 499.

Source files
------------

// File: rtl/vecmac_lane_feeder.sv
// vecmac_lane_feeder: multiplies up to 16 unsigned int8 operand pairs per beat,
// reduces the active lanes to one partial sum and streams ceil(ELEMS/lanes)
// beats per vector toward the accumulator, flagging the final beat.
module vecmac_lane_feeder #(
  parameter int ELEMS  = 1000,
  parameter int MAXL   = 16,
  parameter int W_OUT  = 20,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4:0]             lanes_i,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MAXL*DATA_W-1:0] a_i,
  input  logic [MAXL*DATA_W-1:0] b_i,
  output logic                   ps_valid,
  output logic [W_OUT-1:0]       partial_sum,
  output logic                   ps_last,
  output logic                   done,
  output logic                   cfg_err
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(ELEMS + MAXL);
  localparam logic [CNT_W-1:0] ELEMS_C = CNT_W'(ELEMS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [4:0]         lanes_q;
  logic [CNT_W-1:0]   elem_cnt;
  logic               lanes_ok;
  logic               accept;
  logic               last_beat;
  logic [MAXL-1:0]    lane_act;

  logic [PROD_W-1:0]  prod_p1 [MAXL];
  logic               vld_p1;
  logic               last_p1;
  logic [W_OUT-1:0]   sum_nxt;
  logic [W_OUT-1:0]   sum_p2;
  logic               vld_p2;
  logic               last_p2;

  // Masked lane product; an inactive lane contributes nothing to the sum.
  function automatic logic [PROD_W-1:0] lane_product(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic              act
  );
    lane_product = act ? (PROD_W'(a) * PROD_W'(b)) : '0;
  endfunction

  // Only power-of-two lane counts up to MAXL are supported.
  always_comb begin
    lanes_ok = 1'b0;
    case (lanes_i)
      5'd1, 5'd2, 5'd4, 5'd8, 5'd16: lanes_ok = 1'b1;
      default:                        lanes_ok = 1'b0;
    endcase
  end

  // Lane k carries a real element only below the configured width and the vector end.
  always_comb begin
    for (int k = 0; k < MAXL; k++) begin
      lane_act[k] = (5'(k) < lanes_q) && ((elem_cnt + CNT_W'(k)) < ELEMS_C);
    end
  end

  assign last_beat = (elem_cnt + CNT_W'(lanes_q)) >= ELEMS_C;
  assign accept    = in_valid && in_ready;

  // Next-state and in_ready decode; in_ready depends on state only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (vld_p2 && last_p2) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, lane configuration, element counter and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      lanes_q  <= 5'd1;
      elem_cnt <= '0;
      cfg_err  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= 1'b0;
      done    <= (state == S_DRAIN) && vld_p2 && last_p2;
      if ((state == S_IDLE) && start) begin
        lanes_q  <= lanes_ok ? lanes_i : 5'd1;
        cfg_err  <= ~lanes_ok;
        elem_cnt <= '0;
      end else if (accept) begin
        elem_cnt <= elem_cnt + CNT_W'(lanes_q);
      end
    end
  end

  // ---- stage p1: masked lane products ----
  // Product registers are pure data and carry no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < MAXL; k++) begin
      prod_p1[k] <= lane_product(a_i[k*DATA_W +: DATA_W], b_i[k*DATA_W +: DATA_W], lane_act[k]);
    end
  end

  // Stage p1 valid/last follow the accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= accept;
      last_p1 <= accept && last_beat;
    end
  end

  // Adder tree over all lanes; masked lanes are already zero.
  always_comb begin
    sum_nxt = '0;
    for (int k = 0; k < MAXL; k++) begin
      sum_nxt = sum_nxt + W_OUT'(prod_p1[k]);
    end
  end

  // ---- stage p2: reduced partial sum ----
  // The sum is an output and must read zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      sum_p2  <= '0;
    end else begin
      vld_p2  <= vld_p1;
      last_p2 <= vld_p1 && last_p1;
      sum_p2  <= sum_nxt;
    end
  end

  assign ps_valid    = vld_p2;
  assign partial_sum = sum_p2;
  assign ps_last     = last_p2;

endmodule

// File: tb/tb_vecmac_lane_feeder.sv
// Self-checking bench for vecmac_lane_feeder: each vector is driven beat by
// beat and compared against an element-consumption model of the feeder.
module tb_vecmac_lane_feeder;

  localparam int ELEMS = 1000;
  localparam int MAXL  = 16;
  localparam int W_OUT = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [4:0]        lanes_i = 5'd1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [MAXL*8-1:0] a_i = '0;
  logic [MAXL*8-1:0] b_i = '0;
  logic              ps_valid;
  logic [W_OUT-1:0]  partial_sum;
  logic              ps_last;
  logic              done;
  logic              cfg_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int exp_sum[$];
  int exp_last[$];
  int exp_cyc[$];
  int got_sum[$];
  int got_last[$];
  int got_cyc[$];
  int done_q[$];
  int cfg_q[$];

  vecmac_lane_feeder #(.ELEMS(ELEMS), .MAXL(MAXL), .W_OUT(W_OUT)) dut (
    .clk(clk), .rst(rst), .start(start), .lanes_i(lanes_i),
    .in_valid(in_valid), .in_ready(in_ready), .a_i(a_i), .b_i(b_i),
    .ps_valid(ps_valid), .partial_sum(partial_sum), .ps_last(ps_last),
    .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (ps_valid) begin
      got_sum.push_back(int'(partial_sum));
      got_last.push_back(int'(ps_last));
      got_cyc.push_back(cyc);
    end
    if (done)    done_q.push_back(cyc);
    if (cfg_err) cfg_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    exp_sum.delete(); exp_last.delete(); exp_cyc.delete();
    got_sum.delete(); got_last.delete(); got_cyc.delete();
    done_q.delete(); cfg_q.delete();
  endtask

  // mode 1: all 0xFF; 2: lane0 a=3 b=5, others 0xFF; 4: all zero; else random
  task automatic fill_ops(input int mode);
    for (int k = 0; k < MAXL; k++) begin
      case (mode)
        1: begin a_i[k*8 +: 8] = 8'hFF; b_i[k*8 +: 8] = 8'hFF; end
        2: begin
          a_i[k*8 +: 8] = (k == 0) ? 8'd3 : 8'hFF;
          b_i[k*8 +: 8] = (k == 0) ? 8'd5 : 8'hFF;
        end
        4: begin a_i[k*8 +: 8] = 8'h00; b_i[k*8 +: 8] = 8'h00; end
        default: begin
          a_i[k*8 +: 8] = 8'($urandom_range(255));
          b_i[k*8 +: 8] = 8'($urandom_range(255));
        end
      endcase
    end
  endtask

  // Drives one whole vector. cfg is the value presented on lanes_i at start,
  // eff the lane count the feeder should actually use.
  task automatic run_vector(input logic [4:0] cfg, input int eff, input int mode,
                            input bit mid_start, input int exp_cfg,
                            input longint exp_total, input string tag);
    int     elem;
    int     guard;
    int     n;
    int     s;
    bit     v;
    longint tot;
    clear_q();
    start    = 1'b1;
    lanes_i  = cfg;
    in_valid = 1'b1;
    fill_ops(mode);
    @(negedge clk);
    check({tag, "_rdy_at_start"}, in_ready, 0);
    @(posedge clk); #1;
    start   = 1'b0;
    lanes_i = 5'd16;
    elem  = 0;
    guard = 0;
    while (elem < ELEMS && guard < 5000) begin
      guard++;
      v = (mode == 3) ? guard[0] : 1'b1;
      in_valid = v;
      fill_ops(mode);
      if (mid_start && guard == 20) begin
        start   = 1'b1;
        lanes_i = 5'd7;
      end else begin
        start   = 1'b0;
        lanes_i = 5'd16;
      end
      @(negedge clk);
      if (v && in_ready) begin
        n = (ELEMS - elem < eff) ? (ELEMS - elem) : eff;
        s = 0;
        for (int k = 0; k < n; k++) s += int'(a_i[k*8 +: 8]) * int'(b_i[k*8 +: 8]);
        exp_sum.push_back(s);
        exp_last.push_back((elem + n == ELEMS) ? 1 : 0);
        exp_cyc.push_back(cyc + 2);
        elem += n;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check({tag, "_guard"}, guard < 5000, 1);
    @(negedge clk);
    check({tag, "_rdy_drop"}, in_ready, 0);
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_nbeats"}, got_sum.size(), (ELEMS + eff - 1) / eff);
    check({tag, "_nbeats_model"}, got_sum.size(), exp_sum.size());
    tot = 0;
    for (int i = 0; i < got_sum.size() && i < exp_sum.size(); i++) begin
      check($sformatf("%s_sum%0d", tag, i), got_sum[i], exp_sum[i]);
      check($sformatf("%s_last%0d", tag, i), got_last[i], exp_last[i]);
      check($sformatf("%s_cyc%0d", tag, i), got_cyc[i], exp_cyc[i]);
      tot += got_sum[i];
    end
    if (exp_total >= 0) check({tag, "_total"}, tot, exp_total);
    check({tag, "_ndone"}, done_q.size(), 1);
    if (done_q.size() > 0 && got_cyc.size() > 0)
      check({tag, "_done_cyc"}, done_q[0], got_cyc[got_cyc.size()-1] + 1);
    check({tag, "_cfg_err"}, cfg_q.size(), exp_cfg);
  endtask

  initial begin
    int n_acc;
    int guard;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ps_valid", ps_valid, 0);
    check("rst_partial_sum", partial_sum, 0);
    check("rst_ps_last", ps_last, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // full-scale operands on all 16 lanes
    run_vector(5'd16, 16, 1, 1'b0, 0, 64'd65025000, "l16_max");
    // single lane; upper lanes hold 0xFF and must be ignored
    run_vector(5'd1, 1, 2, 1'b0, 0, 64'd15000, "l1_const");
    // four lanes, random operands, in_valid toggling
    run_vector(5'd4, 4, 3, 1'b0, 0, -1, "l4_gap");
    // illegal width falls back to one lane; a start during RUN is ignored
    run_vector(5'd3, 1, 0, 1'b1, 1, -1, "l3_cfg");

    // eight-lane vector interrupted by reset after 10 accepted beats
    clear_q();
    start   = 1'b1;
    lanes_i = 5'd8;
    @(posedge clk); #1;
    start = 1'b0;
    n_acc = 0;
    guard = 0;
    while (n_acc < 10 && guard < 100) begin
      guard++;
      in_valid = 1'b1;
      fill_ops(0);
      @(negedge clk);
      if (in_ready) n_acc++;
      @(posedge clk); #1;
    end
    check("rstmid_accepts", n_acc, 10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rstmid_ps_valid", ps_valid, 0);
    check("rstmid_ps_last", ps_last, 0);
    check("rstmid_done", done, 0);
    check("rstmid_in_ready", in_ready, 0);
    @(posedge clk); #1;
    clear_q();
    repeat (6) @(posedge clk);
    #1;
    check("rstmid_no_done", done_q.size(), 0);
    check("rstmid_no_beats", got_sum.size(), 0);
    run_vector(5'd8, 8, 0, 1'b0, 0, -1, "l8_clean");

    // zero operands on two lanes
    run_vector(5'd2, 2, 4, 1'b0, 0, 64'd0, "l2_zero");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
